// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the icache from the PC, fills the IF/ID register and gates PC advance.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int                 WORD_W    = 32,
  parameter logic [WORD_W-1:0]  NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] pc_add4,
  output logic              pc_enable,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              stall,
  input  logic              flush,
  input  logic              halt,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc4,
  output logic [31:0]       perf_fetches,
  output logic [31:0]       perf_miss_cycles
);

  typedef enum logic [1:0] {REQ, DRAIN, HALT} state_t;

  state_t            state, next_state;
  logic [WORD_W-1:0] drain_addr;
  logic              ifid_load, ifid_flush, ifid_bubble;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= REQ;
      drain_addr <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
    end else begin
      state <= next_state;
      if (state == REQ) drain_addr <= iaddr;
      if (ifid_load) begin
        ifid_valid <= 1'b1;
        ifid_instr <= iload;
        ifid_pc4   <= pc_add4;
      end else if (ifid_flush) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (ifid_bubble) begin
        ifid_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state  = state;
    imemREN     = 1'b0;
    imemaddr    = iaddr;
    pc_enable   = 1'b0;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_bubble = 1'b0;
    case (state)
      REQ: begin
        imemREN = 1'b1;
        if (flush) begin
          // Redirect loads now; an outstanding miss must still be drained from the blocking cache.
          pc_enable  = 1'b1;
          ifid_flush = 1'b1;
          if (!ihit) next_state = DRAIN;
        end else if (halt) begin
          ifid_bubble = 1'b1;
          next_state  = HALT;
        end else if (stall) begin
          // IF/ID and PC hold; hit data is dropped and refetched.
        end else if (ihit) begin
          pc_enable = 1'b1;
          ifid_load = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      DRAIN: begin
        imemREN     = 1'b1;
        imemaddr    = drain_addr;
        ifid_bubble = 1'b1;
        if (ihit) next_state = REQ;
      end
      HALT: begin
        ifid_bubble = 1'b1;
      end
      default: next_state = REQ;
    endcase
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_fetches     <= '0;
      perf_miss_cycles <= '0;
    end else begin
      if (ifid_load) perf_fetches <= perf_fetches + 32'd1;
      if (state == REQ && !ihit) perf_miss_cycles <= perf_miss_cycles + 32'd1;
    end
  end
`else
  assign perf_fetches     = '0;
  assign perf_miss_cycles = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Drives the icache request from the PC address and captures hit data plus PC+4 into the IF/ID pipeline register.
- Generates the PC advance enable, so the PC steps only when an instruction is accepted or a redirect must take effect.
- Handles decode stalls, branch/jump flushes (including a flush arriving mid-miss), and halt.

Parameters:
- WORD_W, 32, data/address width (matches word_t).
- NOP_INSTR, 32'h00000000, value loaded into ifid_instr on flush/reset.

Ports:
- clk  input  1  clock; rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- iaddr  input  WORD_W  current PC value.
- pc_add4  input  WORD_W  current PC + 4.
- pc_enable  output  1  PC advance/redirect enable.
- imemREN  output  1  icache read enable.
- imemaddr  output  WORD_W  icache read address.
- ihit  input  1  icache data valid this cycle.
- iload  input  WORD_W  icache read data.
- stall  input  1  hazard unit: hold IF/ID and PC.
- flush  input  1  branch/jump resolved taken; PC redirect is presented this cycle.
- halt  input  1  halt instruction decoded.
- ifid_valid  output  1  IF/ID holds a valid instruction.
- ifid_instr  output  WORD_W  IF/ID instruction.
- ifid_pc4  output  WORD_W  IF/ID PC+4.
- perf_fetches  output  32  accepted-fetch count (see Optional Feature).
- perf_miss_cycles  output  32  REQ cycles with imemREN=1 and ihit=0 (see Optional Feature).

Behaviour:
- Reset (async): state=REQ; ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0; internal drain_addr=0; perf counters=0.
- FSM states: REQ, DRAIN, HALT. Outputs are combinational from the state and inputs; IF/ID and state are registered.
- Priority in REQ: flush > halt > stall > normal.
- REQ, outputs: imemREN=1, imemaddr=iaddr; drain_addr<=iaddr every REQ cycle.
- REQ, flush=1:
  - pc_enable=1 so the redirect loads; ifid_valid<=0, ifid_instr<=NOP_INSTR.
  - If ihit=0 (miss outstanding): next=DRAIN. If ihit=1: stay REQ.
  - iload is discarded in both cases.
- REQ, halt=1 (flush=0): pc_enable=0; ifid_valid<=0; next=HALT.
- REQ, stall=1: pc_enable=0; IF/ID holds its contents; any hit data is discarded and refetched later.
- REQ, ihit=1, no flush/halt/stall: pc_enable=1; ifid_valid<=1, ifid_instr<=iload, ifid_pc4<=pc_add4. Latency is 1 cycle from PC to IF/ID on a hit; sustained throughput is 1 instruction/cycle.
- REQ, ihit=0, no flush/halt/stall: pc_enable=0; ifid_valid<=0 (bubble); IF/ID instr/pc4 hold.
- DRAIN:
  - Outputs: imemREN=1, imemaddr=drain_addr (the old miss address is held so the blocking cache completes), pc_enable=0, ifid_valid<=0.
  - On ihit: data discarded; next=REQ.
  - A further flush in DRAIN is ignored; the PC has already been redirected.
  - halt in DRAIN is ignored.
- HALT: imemREN=0, pc_enable=0, ifid_valid=0. Sticky until reset.
- stall with ifid_valid=0 still holds the register (no spurious valid).
- Reset asserted mid-miss or mid-drain returns immediately to REQ with all outputs at reset values.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetches increments on each accepted fetch (the normal-hit case).
  - perf_miss_cycles increments on each REQ cycle with ihit=0.
  - Both are 32-bit, wrap at 2^32, frozen in HALT.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then iaddr=0x0, pc_add4=0x4, ihit=1, iload=0x8C220004 -> pc_enable=1 same cycle; next edge ifid_valid=1, ifid_instr=0x8C220004, ifid_pc4=0x4.
- Miss for 3 cycles at iaddr=0x10, then ihit with iload=0x00851020 -> imemREN=1, pc_enable=0 and ifid_valid=0 for 3 cycles; 4th cycle pc_enable=1, then IF/ID=0x00851020/0x14; perf_miss_cycles=3 with FETCH_PERF_EN.
- stall=1 for 2 cycles while ihit=1 -> pc_enable=0, IF/ID unchanged both cycles; after release, normal fetch resumes.
- flush during miss at iaddr=0x20, PC redirects to 0x40 -> pc_enable=1 for that cycle, then DRAIN with imemaddr=0x20 until ihit (data dropped), then REQ with imemaddr=0x40; ifid_valid=0 throughout.
- flush and stall together with ihit=1 -> pc_enable=1, ifid_valid<=0, ifid_instr<=0.
- halt=1 -> next cycle imemREN=0 and pc_enable=0 permanently; assert n_rst=0 mid-HALT -> REQ, imemREN=1, IF/ID cleared.
